// File: rtl/pb_port_master.sv
// Port I/O bus initiator: turns valid/ready read/write commands into
// port_id/out_port/strobe cycles and returns read data; also latches interrupt edges.
module pb_port_master #(
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic [7:0]  PORT_ID_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    input  logic       interrupt,
    input  logic       irq_clear,
    output logic       irq_pending,
    output logic       busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

    if (READ_LATENCY == 0 || READ_LATENCY > 15) begin : g_bad_latency
        $error("pb_port_master: READ_LATENCY must be in 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state, state_nxt;
    logic                is_write, is_write_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic                irq_prev;
    logic [DATA_W-1:0]   port_id_nxt, out_port_nxt, rsp_rdata_nxt;
    logic                wstb_nxt, rstb_nxt, rsp_valid_nxt, irq_pending_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // State and registered bus/response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            is_write     <= 1'b0;
            wait_cnt     <= '0;
            irq_prev     <= 1'b0;
            port_id      <= PORT_ID_RESET;
            out_port     <= '0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            irq_pending  <= 1'b0;
        end else begin
            state        <= state_nxt;
            is_write     <= is_write_nxt;
            wait_cnt     <= wait_cnt_nxt;
            irq_prev     <= interrupt;
            port_id      <= port_id_nxt;
            out_port     <= out_port_nxt;
            write_strobe <= wstb_nxt;
            read_strobe  <= rstb_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
            irq_pending  <= irq_pending_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt       = state;
        is_write_nxt    = is_write;
        wait_cnt_nxt    = wait_cnt;
        port_id_nxt     = port_id;
        out_port_nxt    = out_port;
        wstb_nxt        = 1'b0;
        rstb_nxt        = 1'b0;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        // A new edge wins over a same-cycle clear
        irq_pending_nxt = (interrupt & ~irq_prev) | (irq_pending & ~irq_clear);

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    is_write_nxt = cmd_write;
                    port_id_nxt  = cmd_addr;
                    out_port_nxt = cmd_write ? cmd_wdata : '0;
                    state_nxt    = S_SETUP;
                end
            end
            S_SETUP: begin
                wstb_nxt  = is_write;
                rstb_nxt  = ~is_write;
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (is_write) begin
                    rsp_rdata_nxt = '0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end else if (READ_LATENCY == 1) begin
                    rsp_rdata_nxt = in_port;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end else begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    rsp_rdata_nxt = in_port;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pb_port_master.sv
// Directed and randomized bench for pb_port_master with a register-file
// responder; a second instance exercises READ_LATENCY=3.
module tb_pb_port_master;

    localparam logic [7:0] PID_RST = 8'h7E;

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
    logic [7:0] cmd_addr, cmd_wdata, rsp_rdata, port_id, out_port, in_port;
    logic       write_strobe, read_strobe, interrupt, irq_clear, irq_pending, busy;

    logic       c3_valid, c3_ready, c3_write, r3_valid, r3_ready;
    logic [7:0] c3_addr, c3_wdata, r3_rdata, p3_id, o3_port, i3_port;
    logic       w3_stb, r3_stb, int3, clr3, irq3_pend, busy3;

    pb_port_master #(.READ_LATENCY(1), .PORT_ID_RESET(PID_RST)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .interrupt(interrupt), .irq_clear(irq_clear), .irq_pending(irq_pending),
        .busy(busy)
    );

    pb_port_master #(.READ_LATENCY(3), .PORT_ID_RESET(8'h00)) u_dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
        .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
        .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_rdata(r3_rdata),
        .port_id(p3_id), .out_port(o3_port),
        .write_strobe(w3_stb), .read_strobe(r3_stb), .in_port(i3_port),
        .interrupt(int3), .irq_clear(clr3), .irq_pending(irq3_pend),
        .busy(busy3)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h59;
    endfunction

    // Responder register file: registers read data, captures writes on the strobe
    logic [7:0] mem [256];
    logic [7:0] model [256];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            in_port <= 8'h00;
        end else begin
            if (write_strobe) mem[port_id] <= out_port;
            in_port <= mem[port_id];
        end
    end

    always @(posedge clk) i3_port <= (p3_id == 8'h03) ? 8'h5A : 8'h00;

    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [7:0] last_wa, last_wd;
    always @(posedge clk) begin
        if (write_strobe) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= port_id;
            last_wd <= out_port;
        end
        if (read_strobe) rd_cnt <= rd_cnt + 1;
        if (write_strobe && read_strobe) both_cnt <= both_cnt + 1;
    end

    // Called #1 after a rising edge with the master idle
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input int stall, output logic [7:0] rdata, output int cyc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (stall) begin @(posedge clk); #1; end
        rdata = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    int cyc, snap_w, snap_r;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        interrupt = 0; irq_clear = 0;
        c3_valid = 0; c3_write = 0; c3_addr = 0; c3_wdata = 0; r3_ready = 0;
        int3 = 0; clr3 = 0;
        for (int i = 0; i < 256; i++) model[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("rst_port_id", 32'(port_id), 32'(PID_RST));
        check("rst_out_port", 32'(out_port), 32'h00);
        check("rst_strobes", 32'({write_strobe, read_strobe}), 32'd0);
        check("rst_irq", 32'(irq_pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Single write
        snap_w = wr_cnt; snap_r = rd_cnt;
        issue(1'b1, 8'h02, 8'hA5, 0, rd, cyc);
        model[8'h02] = 8'hA5;
        check("wr_latency", 32'(cyc), 32'd3);
        check("wr_rdata", 32'(rd), 32'h00);
        check("wr_strobe_count", 32'(wr_cnt - snap_w), 32'd1);
        check("wr_no_read_strobe", 32'(rd_cnt - snap_r), 32'd0);
        check("wr_strobe_addr", 32'(last_wa), 32'h02);
        check("wr_strobe_data", 32'(last_wd), 32'hA5);
        check("wr_hold_port_id", 32'(port_id), 32'h02);
        check("wr_hold_out_port", 32'(out_port), 32'hA5);
        check("wr_idle_busy", 32'(busy), 32'd0);

        // Read with latency 1
        snap_r = rd_cnt;
        issue(1'b0, 8'h03, 8'hFF, 1, rd, cyc);
        check("rd1_latency", 32'(cyc), 32'd3);
        check("rd1_rdata", 32'(rd), 32'h5A);
        check("rd1_strobe_count", 32'(rd_cnt - snap_r), 32'd1);
        check("rd1_out_port_zero", 32'(out_port), 32'h00);

        // Read with latency 3
        c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 8'h03;
        @(posedge clk); #1;
        c3_valid = 1'b0;
        cyc = 1;
        while (!r3_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("rd3_latency", 32'(cyc), 32'd5);
        check("rd3_rdata", 32'(r3_rdata), 32'h5A);
        r3_ready = 1'b1;
        @(posedge clk); #1;
        r3_ready = 1'b0;
        check("rd3_done", 32'(r3_valid), 32'd0);
        check("rd3_ready", 32'(c3_ready), 32'd1);

        // Response backpressure with a second command waiting
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h11;
        @(posedge clk); #1;
        cmd_addr = 8'h11; cmd_wdata = 8'h22;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("bp_first_latency", 32'(cyc), 32'd3);
        snap_w = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", 32'(rsp_rdata), 32'h00);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        check("bp_no_strobe", 32'(wr_cnt - snap_w), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_hs_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_second_port_id", 32'(port_id), 32'h11);
        check("bp_second_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("bp_second_latency", 32'(cyc), 32'd3);
        check("bp_second_strobe", 32'(wr_cnt - snap_w), 32'd1);
        check("bp_second_addr", 32'(last_wa), 32'h11);
        check("bp_second_data", 32'(last_wd), 32'h22);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        model[8'h10] = 8'h11;
        model[8'h11] = 8'h22;

        // Interrupt edge latch
        interrupt = 1'b1; irq_clear = 1'b1;
        @(posedge clk); #1;
        check("irq_set_wins", 32'(irq_pending), 32'd1);
        @(posedge clk); #1;
        check("irq_cleared", 32'(irq_pending), 32'd0);
        irq_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("irq_level_no_reset", 32'(irq_pending), 32'd0);
        interrupt = 1'b0;
        @(posedge clk); #1;
        interrupt = 1'b1;
        @(posedge clk); #1;
        check("irq_new_edge", 32'(irq_pending), 32'd1);
        @(posedge clk); #1;
        check("irq_sticky", 32'(irq_pending), 32'd1);
        irq_clear = 1'b1;
        @(posedge clk); #1;
        irq_clear = 1'b0; interrupt = 1'b0;
        check("irq_clear2", 32'(irq_pending), 32'd0);

        // Reset during the strobe cycle
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_strobe_up", 32'(read_strobe), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_strobe_drop", 32'({write_strobe, read_strobe}), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_port_id", 32'(port_id), 32'(PID_RST));
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = init_val(i);
        @(posedge clk); #1;
        check("post_rst_idle", 32'(cmd_ready), 32'd1);
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        issue(1'b0, 8'h03, 8'h00, 0, rd, cyc);
        check("post_rst_read", 32'(rd), 32'h5A);

        // Randomized traffic against the model
        for (int n = 0; n < 1000; n++) begin
            logic       w;
            logic [7:0] a, d, exp;
            int         st;
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 15));
            d  = 8'($urandom);
            st = $urandom_range(0, 3);
            exp = w ? 8'h00 : model[a];
            if (w) model[a] = d;
            check("rnd_idle", 32'(cmd_ready), 32'd1);
            snap_w = wr_cnt; snap_r = rd_cnt;
            issue(w, a, d, st, rd, cyc);
            check("rnd_latency", 32'(cyc), 32'd3);
            check("rnd_rdata", 32'(rd), 32'(exp));
            check("rnd_wr_strobes", 32'(wr_cnt - snap_w), 32'(w));
            check("rnd_rd_strobes", 32'(rd_cnt - snap_r), 32'(!w));
        end
        check("strobes_never_both", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
